alu_ctrl: RTL

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl_pkg.sv | 41 ++++
 rtl/alu_ctrl_regfile.sv | 32 +++
 rtl/alu_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU controller: opcodes, FSM encoding and the
// bit positions of each field inside the 16-bit instruction word.
package alu_ctrl_pkg;

  // Instruction field positions
  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;
  localparam int unsigned RD_MSB = 11;
  localparam int unsigned RD_LSB = 10;
  localparam int unsigned RA_MSB = 9;
  localparam int unsigned RA_LSB = 8;
  localparam int unsigned RB_MSB = 7;
  localparam int unsigned RB_LSB = 6;
  localparam int unsigned SH_MSB = 5;
  localparam int unsigned SH_LSB = 3;

  typedef logic [3:0] opcode_t;

  // Opcodes understood by the external ALU; the controller passes them through
  localparam opcode_t OP_NOT  = 4'b1000;
  localparam opcode_t OP_AND  = 4'b1001;
  localparam opcode_t OP_OR   = 4'b1010;
  localparam opcode_t OP_CMP  = 4'b1011;
  localparam opcode_t OP_ADD  = 4'b1100;
  localparam opcode_t OP_SUB  = 4'b1101;
  // Opcodes the controller rejects
  localparam opcode_t OP_ILL0 = 4'b1110;
  localparam opcode_t OP_ILL1 = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

  function automatic logic op_is_illegal(input opcode_t op);
    return (op == OP_ILL0) || (op == OP_ILL1);
  endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// 4x8 register file: one write port, two operand read ports and a debug read
// port. Reads are combinational, so a write becomes visible the cycle after.
module alu_ctrl_regfile (
  input  logic       clk,
  input  logic       rst,
  input  logic       we_i,
  input  logic [1:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [1:0] raddr_a_i,
  input  logic [1:0] raddr_b_i,
  input  logic [1:0] raddr_dbg_i,
  output logic [7:0] rdata_a_o,
  output logic [7:0] rdata_b_o,
  output logic [7:0] rdata_dbg_o
);

  logic [7:0] regs_q [4];

  // Register storage, cleared on reset, single write per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o   = regs_q[raddr_a_i];
  assign rdata_b_o   = regs_q[raddr_b_i];
  assign rdata_dbg_o = regs_q[raddr_dbg_i];

endmodule

// File: rtl/alu_ctrl.sv
// ALU controller: accepts one instruction at a time, drives the external ALU,
// captures its result and writes it back to the register file.
//
// Handshake: an instruction transfers on the rising edge where instr_valid and
// instr_ready are both 1. instr_ready is high only in IDLE, so instr_valid held
// high in any other state is ignored; the full word is latched at transfer.
module alu_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [15:0] instr,
  output logic [3:0] alu_op,
  output logic [2:0] alu_shamt,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic [1:0] alu_flags,
  output logic       wb_valid,
  output logic [1:0] wb_rd,
  output logic [7:0] wb_data,
  output logic       flag_gt,
  output logic       flag_eq,
  output logic       illegal,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_data,
  output logic [1:0] dbg_state
);

  state_t      state_q, state_d;
  logic [15:0] instr_q;
  logic [7:0]  result_q;
  logic [1:0]  cflags_q;
  logic        flag_gt_q, flag_eq_q;

  opcode_t     op_q;
  logic [1:0]  rd_q, ra_q, rb_q;
  logic [2:0]  sh_q;
  logic        op_cmp, op_ill;
  logic        rf_we;
  logic [7:0]  rf_a, rf_b;

  assign op_q   = instr_q[OP_MSB:OP_LSB];
  assign rd_q   = instr_q[RD_MSB:RD_LSB];
  assign ra_q   = instr_q[RA_MSB:RA_LSB];
  assign rb_q   = instr_q[RB_MSB:RB_LSB];
  assign sh_q   = instr_q[SH_MSB:SH_LSB];
  assign op_cmp = (op_q == OP_CMP);
  assign op_ill = op_is_illegal(op_q);

  alu_ctrl_regfile u_regfile (
    .clk         (clk),
    .rst         (rst),
    .we_i        (rf_we),
    .waddr_i     (rd_q),
    .wdata_i     (result_q),
    .raddr_a_i   (ra_q),
    .raddr_b_i   (rb_q),
    .raddr_dbg_i (dbg_sel),
    .rdata_a_o   (rf_a),
    .rdata_b_o   (rf_b),
    .rdata_dbg_o (dbg_data)
  );

  // FSM state register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Latch the whole instruction word on the accepting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             instr_q <= '0;
    else if (instr_valid && instr_ready) instr_q <= instr;
  end

  // Sample the ALU result and compare flags at the end of CAPTURE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      cflags_q <= '0;
    end else if (state_q == ST_CAPTURE) begin
      result_q <= alu_out;
      cflags_q <= alu_flags;
    end
  end

  // Architectural compare flags change only when a compare retires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_gt_q <= 1'b0;
      flag_eq_q <= 1'b0;
    end else if (state_q == ST_WRITEBACK && op_cmp) begin
      flag_gt_q <= cflags_q[1];
      flag_eq_q <= cflags_q[0];
    end
  end

  // Next-state and output decode; ALU drive held through ISSUE and CAPTURE
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    alu_op      = '0;
    alu_shamt   = '0;
    alu_a       = '0;
    alu_b       = '0;
    illegal     = 1'b0;
    wb_valid    = 1'b0;
    wb_rd       = '0;
    wb_data     = '0;
    rf_we       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (op_ill) begin
          illegal = 1'b1;
          state_d = ST_IDLE;
        end else begin
          alu_op    = op_q;
          alu_shamt = sh_q;
          alu_a     = rf_a;
          alu_b     = rf_b;
          state_d   = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // No register write can happen before WRITEBACK, so the operands
        // read here are the ones seen in ISSUE.
        alu_op    = op_q;
        alu_shamt = sh_q;
        alu_a     = rf_a;
        alu_b     = rf_b;
        state_d   = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        state_d = ST_IDLE;
        if (!op_cmp) begin
          wb_valid = 1'b1;
          wb_rd    = rd_q;
          wb_data  = result_q;
          rf_we    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign flag_gt   = flag_gt_q;
  assign flag_eq   = flag_eq_q;
  assign dbg_state = state_q;

endmodule
